// File: rtl/tag_phase_modulator.sv
// Backscatter tag modulator: delays past the excitation preamble after a trigger edge,
// then phase-modulates a shift square wave with handshaked tag bits onto the RF switch.
module tag_phase_modulator #(
  parameter int DELAY_CYCLES   = 19200,
  parameter int CYCLES_PER_BIT = 400,
  parameter int SHIFT_HALF     = 2,
  parameter int HOLDOFF_CYCLES = 1000,
  parameter int CNT_W          = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger_signal,
  input  logic [7:0] num_bits,
  input  logic       bit_data,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic       signal_into_switch,
  output logic       data_path_signal,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_SEND,
    S_HOLDOFF
  } state_t;

  localparam logic [CNT_W-1:0] L_DELAY_LAST   = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_SLOT_LAST    = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] L_SHIFT_LAST   = CNT_W'(SHIFT_HALF - 1);
  localparam logic [CNT_W-1:0] L_HOLDOFF_LAST = CNT_W'(HOLDOFF_CYCLES - 1);

  logic             r_trig_meta;
  logic             r_trig_sync;
  logic             r_trig_prev;
  logic             w_trig_rise;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [7:0]       r_bit_cnt;
  logic [7:0]       w_bit_cnt_next;
  logic [7:0]       r_num_bits;
  logic [7:0]       w_num_bits_next;
  logic [CNT_W-1:0] r_shift_cnt;
  logic [CNT_W-1:0] w_shift_cnt_next;
  logic             r_sq;
  logic             w_sq_next;
  logic             r_tag_bit;
  logic             w_tag_bit_next;
  logic             r_underrun;
  logic             w_underrun_next;

  logic             r_bit_ready;
  logic             w_bit_ready_next;
  logic             r_signal;
  logic             w_signal_next;
  logic             r_data_path;
  logic             w_data_path_next;
  logic             r_busy;
  logic             w_busy_next;
  logic             r_done;
  logic             w_done_next;
  logic             w_mod_next;

  assign w_trig_rise = r_trig_sync & ~r_trig_prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_trig_meta <= 1'b0;
      r_trig_sync <= 1'b0;
      r_trig_prev <= 1'b0;
    end else begin
      r_trig_meta <= trigger_signal;
      r_trig_sync <= r_trig_meta;
      r_trig_prev <= r_trig_sync;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_cnt   <= '0;
      r_num_bits  <= '0;
      r_shift_cnt <= '0;
      r_sq        <= 1'b0;
      r_tag_bit   <= 1'b0;
      r_underrun  <= 1'b0;
      r_bit_ready <= 1'b0;
      r_signal    <= 1'b0;
      r_data_path <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_bit_cnt   <= w_bit_cnt_next;
      r_num_bits  <= w_num_bits_next;
      r_shift_cnt <= w_shift_cnt_next;
      r_sq        <= w_sq_next;
      r_tag_bit   <= w_tag_bit_next;
      r_underrun  <= w_underrun_next;
      r_bit_ready <= w_bit_ready_next;
      r_signal    <= w_signal_next;
      r_data_path <= w_data_path_next;
      r_busy      <= w_busy_next;
      r_done      <= w_done_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_bit_cnt_next   = r_bit_cnt;
    w_num_bits_next  = r_num_bits;
    w_shift_cnt_next = r_shift_cnt;
    w_sq_next        = r_sq;
    w_tag_bit_next   = r_tag_bit;
    w_underrun_next  = r_underrun;

    // A requested bit that is not offered is sent as 0 and flagged.
    if (r_bit_ready) begin
      if (bit_valid) begin
        w_tag_bit_next = bit_data;
      end else begin
        w_tag_bit_next  = 1'b0;
        w_underrun_next = 1'b1;
      end
    end

    case (r_state)
      S_IDLE: begin
        if (w_trig_rise) begin
          w_state_next     = S_DELAY;
          w_num_bits_next  = num_bits;
          w_underrun_next  = 1'b0;
          w_cnt_next       = '0;
          w_bit_cnt_next   = '0;
          w_shift_cnt_next = '0;
          w_sq_next        = 1'b0;
          w_tag_bit_next   = 1'b0;
        end
      end
      S_DELAY: begin
        if (r_cnt == L_DELAY_LAST) begin
          w_cnt_next     = '0;
          w_bit_cnt_next = '0;
          w_state_next   = (r_num_bits == 8'd0) ? S_HOLDOFF : S_SEND;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_SEND: begin
        if (r_cnt == L_SLOT_LAST) begin
          w_cnt_next = '0;
          if (r_bit_cnt == r_num_bits - 8'd1) begin
            w_state_next = S_HOLDOFF;
          end else begin
            w_bit_cnt_next = r_bit_cnt + 8'd1;
          end
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      S_HOLDOFF: begin
        if (r_cnt == L_HOLDOFF_LAST) begin
          w_cnt_next   = '0;
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase

    // Square wave free-runs across slot boundaries; phase restarts only at DELAY entry.
    w_mod_next = (w_state_next == S_DELAY) || (w_state_next == S_SEND);
    if (w_mod_next) begin
      if (r_state != S_IDLE) begin
        if (r_shift_cnt == L_SHIFT_LAST) begin
          w_shift_cnt_next = '0;
          w_sq_next        = ~r_sq;
        end else begin
          w_shift_cnt_next = r_shift_cnt + CNT_W'(1);
        end
      end
    end else begin
      w_shift_cnt_next = '0;
      w_sq_next        = 1'b0;
    end

    w_bit_ready_next = ((w_state_next == S_DELAY) && (w_cnt_next == L_DELAY_LAST) &&
                        (w_num_bits_next != 8'd0)) ||
                       ((w_state_next == S_SEND) && (w_cnt_next == L_SLOT_LAST) &&
                        (w_bit_cnt_next != w_num_bits_next - 8'd1));
    w_signal_next    = (w_state_next == S_DELAY) ? w_sq_next :
                       (w_state_next == S_SEND)  ? (w_sq_next ^ w_tag_bit_next) : 1'b0;
    w_data_path_next = (w_state_next == S_SEND) & w_tag_bit_next;
    w_busy_next      = (w_state_next != S_IDLE);
    w_done_next      = (w_state_next == S_HOLDOFF) && (r_state != S_HOLDOFF);
  end

  assign bit_ready          = r_bit_ready;
  assign signal_into_switch = r_signal;
  assign data_path_signal   = r_data_path;
  assign busy               = r_busy;
  assign done               = r_done;
  assign underrun           = r_underrun;

endmodule

// File: tb/tb_tag_phase_modulator.sv
// Directed bench for tag_phase_modulator with small timing parameters; each frame is
// compared cycle by cycle against a timeline model counted from DELAY entry.
module tb_tag_phase_modulator;
  localparam int D = 10;
  localparam int C = 8;
  localparam int S = 2;
  localparam int H = 5;

  logic       clock = 1'b0;
  logic       reset;
  logic       trigger_signal;
  logic [7:0] num_bits;
  logic       bit_data;
  logic       bit_valid;
  logic       bit_ready;
  logic       signal_into_switch;
  logic       data_path_signal;
  logic       busy;
  logic       done;
  logic       underrun;

  int tests_run    = 0;
  int tests_failed = 0;

  tag_phase_modulator #(
    .DELAY_CYCLES(D), .CYCLES_PER_BIT(C), .SHIFT_HALF(S), .HOLDOFF_CYCLES(H), .CNT_W(16)
  ) dut (
    .clock(clock), .reset(reset), .trigger_signal(trigger_signal), .num_bits(num_bits),
    .bit_data(bit_data), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .signal_into_switch(signal_into_switch), .data_path_signal(data_path_signal),
    .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clock = ~clock;

  // Expected {busy, bit_ready, signal, data_path, done} in cycle n after DELAY entry.
  function automatic logic [4:0] model(input int n, input int nb, input logic [7:0] sent);
    int   se;
    int   k;
    logic sq;
    logic in_send;
    logic b;
    se      = D + nb * C;
    in_send = (n >= D) && (n < se);
    k       = in_send ? (n - D) / C : 0;
    sq      = ((n / S) % 2) == 1;
    b       = in_send ? sent[k] : 1'b0;
    model[4] = n < se + H;
    model[3] = ((n == D - 1) && (nb != 0)) || (in_send && ((n - D) % C == C - 1) && (k != nb - 1));
    model[2] = (n < D) ? sq : (in_send ? (sq ^ b) : 1'b0);
    model[1] = b;
    model[0] = (n == se);
  endfunction

  function automatic int src_idx(input int n);
    return (n < D) ? 0 : ((n - D) / C + 1) % 8;
  endfunction

  task automatic test_reset();
    reset = 1'b1; trigger_signal = 1'b0; num_bits = 8'd0; bit_data = 1'b0; bit_valid = 1'b0;
    repeat (3) @(negedge clock);
    tests_run++;
    if ({busy, bit_ready, signal_into_switch, data_path_signal, done, underrun} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_hold got %b exp 000000",
               {busy, bit_ready, signal_into_switch, data_path_signal, done, underrun});
    end
    reset = 1'b0;
    @(negedge clock);
    tests_run++;
    if ({busy, bit_ready, signal_into_switch, data_path_signal, done, underrun} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_idle got %b exp 000000",
               {busy, bit_ready, signal_into_switch, data_path_signal, done, underrun});
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_nominal();
    logic [7:0] src = 8'b0000_1101;
    logic [5:0] exp;
    logic [5:0] got;
    int rdy = 0;
    int dn  = 0;
    num_bits = 8'd4; bit_valid = 1'b1; bit_data = src[0];
    @(negedge clock);
    trigger_signal = 1'b1;
    @(negedge clock);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL nom_lat_edge0 busy got %b exp 0", busy); end
    @(negedge clock);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL nom_lat_edge1 busy got %b exp 0", busy); end
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      exp = {model(n, 4, src), 1'b0};
      got = {busy, bit_ready, signal_into_switch, data_path_signal, done, underrun};
      rdy += int'(bit_ready);
      dn  += int'(done);
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL nominal n=%0d got %b exp %b", n, got, exp);
      end
      bit_data = src[src_idx(n)];
    end
    trigger_signal = 1'b0;
    tests_run++;
    if (rdy != 4) begin tests_failed++; $display("FAIL nom_ready_count got %0d exp 4", rdy); end
    tests_run++;
    if (dn != 1) begin tests_failed++; $display("FAIL nom_done_count got %0d exp 1", dn); end
    $display("[TB] nominal frame of 4 bits checked");
  endtask

  task automatic test_underrun();
    logic [7:0] src  = 8'b0000_0111;
    logic [7:0] val  = 8'b1111_1101;
    logic [7:0] sent = 8'b0000_0101;
    logic [5:0] exp;
    logic [5:0] got;
    num_bits = 8'd3; bit_data = src[0]; bit_valid = val[0];
    @(negedge clock);
    trigger_signal = 1'b1;
    repeat (3) @(posedge clock);
    for (int n = 0; n < 40; n++) begin
      @(negedge clock);
      exp = {model(n, 3, sent), (n >= D + C)};
      got = {busy, bit_ready, signal_into_switch, data_path_signal, done, underrun};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL underrun n=%0d got %b exp %b", n, got, exp);
      end
      bit_data  = src[src_idx(n)];
      bit_valid = val[src_idx(n)];
    end
    trigger_signal = 1'b0; bit_valid = 1'b1;
    $display("[TB] underrun frame checked");
  endtask

  task automatic test_zero_length();
    logic [5:0] exp;
    logic [5:0] got;
    int rdy = 0;
    num_bits = 8'd0;
    @(negedge clock);
    tests_run++;
    if (underrun !== 1'b1) begin tests_failed++; $display("FAIL zero_sticky_underrun got %b exp 1", underrun); end
    trigger_signal = 1'b1;
    repeat (3) @(posedge clock);
    for (int n = 0; n < 17; n++) begin
      @(negedge clock);
      exp = {model(n, 0, 8'd0), 1'b0};
      got = {busy, bit_ready, signal_into_switch, data_path_signal, done, underrun};
      rdy += int'(bit_ready);
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL zero_len n=%0d got %b exp %b", n, got, exp);
      end
    end
    trigger_signal = 1'b0;
    tests_run++;
    if (rdy != 0) begin tests_failed++; $display("FAIL zero_ready_count got %0d exp 0", rdy); end
    $display("[TB] zero-length frame checked");
  endtask

  task automatic test_retrigger();
    logic [7:0] src_a = 8'b0000_0010;
    logic [7:0] src_b = 8'b0000_0001;
    logic [5:0] exp;
    logic [5:0] got;
    num_bits = 8'd2; bit_valid = 1'b1; bit_data = src_a[0];
    @(negedge clock);
    trigger_signal = 1'b1;
    repeat (3) @(posedge clock);
    for (int n = 0; n < 34; n++) begin
      @(negedge clock);
      exp = {model(n, 2, src_a), 1'b0};
      got = {busy, bit_ready, signal_into_switch, data_path_signal, done, underrun};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL retrig_a n=%0d got %b exp %b", n, got, exp);
      end
      bit_data = src_a[src_idx(n)];
      if (n == 12 || n == 20 || n == 29) trigger_signal = 1'b0;
      if (n == 14 || n == 27 || n == 31) trigger_signal = 1'b1;
      if (n >= 31) bit_data = src_b[0];
    end
    for (int n = 0; n < 41; n++) begin
      @(negedge clock);
      exp = {model(n, 2, src_b), 1'b0};
      got = {busy, bit_ready, signal_into_switch, data_path_signal, done, underrun};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL retrig_b n=%0d got %b exp %b", n, got, exp);
      end
      bit_data = src_b[src_idx(n)];
      if (n == 5) trigger_signal = 1'b0;
      if (n == 28) trigger_signal = 1'b1;
    end
    trigger_signal = 1'b0;
    $display("[TB] retrigger and back-to-back frames checked");
  endtask

  task automatic test_reset_mid_send();
    logic [7:0] src = 8'b0000_1101;
    logic [5:0] exp;
    logic [5:0] got;
    num_bits = 8'd4; bit_valid = 1'b1; bit_data = src[0];
    @(negedge clock);
    trigger_signal = 1'b1;
    repeat (3) @(posedge clock);
    for (int n = 0; n <= D + 2 * C; n++) begin
      @(negedge clock);
      exp = {model(n, 4, src), 1'b0};
      got = {busy, bit_ready, signal_into_switch, data_path_signal, done, underrun};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL pre_reset n=%0d got %b exp %b", n, got, exp);
      end
      bit_data = src[src_idx(n)];
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if ({busy, bit_ready, signal_into_switch, data_path_signal, done, underrun} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_async got %b exp 000000",
               {busy, bit_ready, signal_into_switch, data_path_signal, done, underrun});
    end
    @(negedge clock);
    tests_run++;
    if ({busy, bit_ready, signal_into_switch, data_path_signal, done, underrun} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_hold got %b exp 000000",
               {busy, bit_ready, signal_into_switch, data_path_signal, done, underrun});
    end
    reset = 1'b0; trigger_signal = 1'b0;
    repeat (2) @(negedge clock);
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_release_idle busy got %b exp 0", busy); end
    $display("[TB] reset mid-send checked, running full frame");
    test_nominal();
  endtask

  task automatic test_glitch();
    logic [7:0] src = 8'b0000_0001;
    logic [5:0] exp;
    logic [5:0] got;
    num_bits = 8'd1; bit_valid = 1'b1; bit_data = src[0];
    @(negedge clock);
    trigger_signal = 1'b1;
    repeat (3) @(posedge clock);
    for (int n = 0; n < 28; n++) begin
      @(negedge clock);
      exp = {model(n, 1, src), 1'b0};
      got = {busy, bit_ready, signal_into_switch, data_path_signal, done, underrun};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL glitch_a n=%0d got %b exp %b", n, got, exp);
      end
      bit_data = src[0];
      if (n == 3 || n == 13 || n == 26) trigger_signal = 1'b0;
      if (n == 12 || n == 25) trigger_signal = 1'b1;
    end
    for (int n = 0; n < 25; n++) begin
      @(negedge clock);
      exp = {model(n, 1, src), 1'b0};
      got = {busy, bit_ready, signal_into_switch, data_path_signal, done, underrun};
      tests_run++;
      if (got !== exp) begin
        tests_failed++;
        $display("FAIL glitch_b n=%0d got %b exp %b", n, got, exp);
      end
    end
    $display("[TB] glitch pulse checked");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_underrun();
    test_zero_length();
    test_retrigger();
    test_reset_mid_send();
    test_glitch();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
